// File: rtl/pixel_scanout.sv
// pixel_scanout: low-resolution frame buffer scanned out as VGA timing.
// A GRID_W x GRID_H x 3-bit buffer (160x120 at defaults) is written from the
// system clock and displayed pixel-replicated by 2**SCALE_LOG2 in each axis.
// Horizontal/vertical porches and sync widths are fixed offsets from the
// visible size, so the defaults give standard 640x480 @ 25 MHz pixel timing.
// Optional build macro: PIXEL_SCANOUT_TEST_PATTERN_EN replaces buffer data
// with vertical colour bars (colour = h[9:7]); timing and writes unchanged.
module pixel_scanout #(
   parameter int H_VISIBLE  = 640,
   parameter int V_VISIBLE  = 480,
   parameter int SCALE_LOG2 = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   input  logic       plot,
   output logic       vga_clk,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       vga_sync_n,
   output logic [9:0] vga_r,
   output logic [9:0] vga_g,
   output logic [9:0] vga_b,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + 160;
   localparam int V_TOTAL = V_VISIBLE + 45;
   localparam int GRID_W  = H_VISIBLE >> SCALE_LOG2;
   localparam int GRID_H  = V_VISIBLE >> SCALE_LOG2;
   localparam int DEPTH   = GRID_W * GRID_H;
   localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + 16);
   localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + 111);
   localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + 10);
   localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + 11);

   // Spread one colour bit over a full 10-bit DAC channel.
   function automatic logic [9:0] rep10(input logic b);
      return {10{b}};
   endfunction

   logic [2:0]        fb [DEPTH];

   logic              pix_en;
   logic [9:0]        h_cnt;
   logic [9:0]        v_cnt;

   logic              wr_ok;
   logic [ADDR_W-1:0] wr_addr;
   logic              rd_vis;
   logic [ADDR_W-1:0] rd_addr;
   logic              hsync_raw;
   logic              vsync_raw;

   // Sync flags are carried active-high so every pipeline register clears
   // to 0; the pins are inverted at the output.
   logic [ADDR_W-1:0] addr_p0;
   logic              hsync_p0;
   logic              vsync_p0;
   logic              vld_p0;
   logic              hsync_p1;
   logic              vsync_p1;
   logic              vld_p1;
   logic [2:0]        pix_p1;
`ifdef PIXEL_SCANOUT_TEST_PATTERN_EN
   logic [2:0]        pat_p0;
`endif

   assign wr_ok   = plot && (32'(x) < 32'(GRID_W)) && (32'(y) < 32'(GRID_H));
   assign wr_addr = ADDR_W'(32'(y) * 32'(GRID_W) + 32'(x));

   assign rd_vis  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign rd_addr = rd_vis ? ADDR_W'(32'(v_cnt >> SCALE_LOG2) * 32'(GRID_W)
                                     + 32'(h_cnt >> SCALE_LOG2))
                           : '0;

   assign hsync_raw = (h_cnt >= H_SYNC_LO) && (h_cnt <= H_SYNC_HI);
   assign vsync_raw = (v_cnt >= V_SYNC_LO) && (v_cnt <= V_SYNC_HI);

   // Pixel enable, scan counters, two-step read pipeline and the buffer write
   // port. The buffer itself is never cleared; reset only holds off writes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_en   <= 1'b0;
         h_cnt    <= '0;
         v_cnt    <= '0;
         addr_p0  <= '0;
         hsync_p0 <= 1'b0;
         vsync_p0 <= 1'b0;
         vld_p0   <= 1'b0;
         hsync_p1 <= 1'b0;
         vsync_p1 <= 1'b0;
         vld_p1   <= 1'b0;
         pix_p1   <= '0;
`ifdef PIXEL_SCANOUT_TEST_PATTERN_EN
         pat_p0   <= '0;
`endif
      end else begin
         pix_en <= ~pix_en;
         // Non-blocking write: a same-edge read of this address sees old data.
         if (wr_ok) begin
            fb[wr_addr] <= colour;
         end
         if (pix_en) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
            // stage p0: registered read address and timing for this pixel
            addr_p0  <= rd_addr;
            hsync_p0 <= hsync_raw;
            vsync_p0 <= vsync_raw;
            vld_p0   <= rd_vis;
`ifdef PIXEL_SCANOUT_TEST_PATTERN_EN
            pat_p0   <= h_cnt[9:7];
`endif
            // stage p1: pixel data, timing delayed to stay aligned with it
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
            vld_p1   <= vld_p0;
`ifdef PIXEL_SCANOUT_TEST_PATTERN_EN
            pix_p1   <= vld_p0 ? pat_p0 : 3'b000;
`else
            pix_p1   <= vld_p0 ? fb[addr_p0] : 3'b000;
`endif
         end
      end
   end

   assign vga_clk     = pix_en;
   assign vga_hs      = ~hsync_p1;
   assign vga_vs      = ~vsync_p1;
   assign vga_blank_n = vld_p1;
   assign vga_sync_n  = 1'b0;
   assign vga_r       = rep10(pix_p1[2] & vld_p1);
   assign vga_g       = rep10(pix_p1[1] & vld_p1);
   assign vga_b       = rep10(pix_p1[0] & vld_p1);
   assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_pixel_scanout.sv
// Scoreboard bench for pixel_scanout, built with a reduced raster
// (32x8 visible, 8x2 grid) so several whole frames fit in a short run.
module tb_pixel_scanout;

   localparam int HV = 32;
   localparam int VV = 8;
   localparam int SL = 2;
   localparam int HT = HV + 160;
   localparam int VT = VV + 45;
   localparam int FT = HT * VT;
   localparam int GW = HV >> SL;
   localparam int GH = VV >> SL;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
   logic [9:0] vga_r, vga_g, vga_b;

   always #5 clk = ~clk;

   pixel_scanout #(.H_VISIBLE(HV), .V_VISIBLE(VV), .SCALE_LOG2(SL)) dut (
      .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
      .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int fs_count = 0;

   typedef struct {
      int          key;
      logic [32:0] exp;
   } sb_t;
   sb_t sb_q[$];

   logic [2:0] exp_grid [GH][GW];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected {r,g,b,hs,vs,blank_n} for raster position (h,v).
   function automatic logic [32:0] expect_px(input int h, input int v);
      logic [2:0] c;
      logic bl, hs, vs;
      bl = (h < HV) && (v < VV);
`ifdef PIXEL_SCANOUT_TEST_PATTERN_EN
      c  = bl ? 3'((h >> 7) & 7) : 3'b000;
`else
      c  = bl ? exp_grid[v >> SL][h >> SL] : 3'b000;
`endif
      hs = !((h >= HV + 16) && (h <= HV + 111));
      vs = !((v >= VV + 10) && (v <= VV + 11));
      return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}, hs, vs, bl};
   endfunction

   task automatic push_frame(input int fr);
      for (int v = 0; v < VT; v++)
         for (int h = 0; h < HT; h++)
            sb_q.push_back('{fr * FT + v * HT + h, expect_px(h, v)});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " vga_hs"}, vga_hs, 1);
      check({tag, " vga_vs"}, vga_vs, 1);
      check({tag, " blank_n"}, vga_blank_n, 0);
      check({tag, " rgb"}, {vga_r, vga_g, vga_b}, 0);
      check({tag, " frame_start"}, frame_start, 0);
      check({tag, " vga_clk"}, vga_clk, 0);
      check({tag, " sync_n"}, vga_sync_n, 0);
   endtask

   // Caller is just after a posedge; the write lands on the next edge.
   task automatic plot_px(input int px, input int py, input logic [2:0] c);
      x = 8'(px); y = 7'(py); colour = c; plot = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic wait_fs(input int n, input int budget);
      int c = 0;
      while (fs_count < n && c < budget) begin
         @(posedge clk); c++;
      end
      check($sformatf("frame_start %0d reached", n), fs_count >= n, 1);
   endtask

   // Scan monitor: locks to frame_start, tracks which pixel is on the pins
   // (two pix_en steps behind the counter) and retires scoreboard entries.
   initial begin : monitor
      int  k = 0;
      bit  synced = 0;
      int  key, f, r;
      logic [32:0] act;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            synced = 0;
         end else if (frame_start) begin
            if (synced) check("frame_start period", k + 1, 2 * FT);
            synced = 1; k = 0; fs_count++;
         end else if (synced) begin
            k++;
            if (k % 2 == 1) begin
               key = fs_count * FT + (k + 1) / 2 - 2;
               act = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n};
               while (sb_q.size() > 0 && sb_q[0].key < key) begin
                  n_checks++;
                  $display("FAIL pixel missed key=%0d got no output expected %h",
                           sb_q[0].key, sb_q[0].exp);
                  void'(sb_q.pop_front());
               end
               if (sb_q.size() > 0 && sb_q[0].key == key) begin
                  n_checks++;
                  if (act === sb_q[0].exp) n_pass++;
                  else begin
                     f = key / FT; r = key % FT;
                     $display("FAIL pixel f=%0d h=%0d v=%0d got %h expected %h",
                              f, r % HT, r / HT, act, sb_q[0].exp);
                  end
                  void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   // Sync pulse period and width measurement.
   initial begin : sync_meas
      logic hs_prev = 1'b1, vs_prev = 1'b1;
      bit   hs_arm = 0, hs_low_arm = 0, vs_arm = 0, vs_low_arm = 0;
      int   hs_since = 0, hs_low = 0, vs_since = 0, vs_low = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            hs_arm = 0; hs_low_arm = 0; vs_arm = 0; vs_low_arm = 0;
            hs_prev = 1'b1; vs_prev = 1'b1;
         end else begin
            hs_since++; vs_since++;
            if (hs_prev && !vga_hs) begin
               if (hs_arm) check("hs period", hs_since, 2 * HT);
               hs_arm = 1; hs_since = 0; hs_low = 0; hs_low_arm = 1;
            end
            if (!vga_hs) hs_low++;
            if (!hs_prev && vga_hs && hs_low_arm) check("hs low width", hs_low, 192);
            if (vs_prev && !vga_vs) begin
               if (vs_arm) check("vs period", vs_since, 2 * FT);
               vs_arm = 1; vs_since = 0; vs_low = 0; vs_low_arm = 1;
            end
            if (!vga_vs) vs_low++;
            if (!vs_prev && vga_vs && vs_low_arm) check("vs low width", vs_low, 4 * HT);
            hs_prev = vga_hs; vs_prev = vga_vs;
         end
      end
   end

   initial begin : watchdog
      repeat (120000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
      for (int gy = 0; gy < GH; gy++)
         for (int gx = 0; gx < GW; gx++)
            exp_grid[gy][gx] = 3'b000;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");

      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      check("fs before first step", frame_start, 0);
      @(negedge clk);
      check("fs first step", frame_start, 1);
      check("vga_clk first step", vga_clk, 1);
      @(negedge clk);
      check("fs one clk wide", frame_start, 0);

      // Clear the buffer, then back-to-back directed writes.
      @(posedge clk); #1;
      for (int gy = 0; gy < GH; gy++)
         for (int gx = 0; gx < GW; gx++)
            plot_px(gx, gy, 3'b000);
      plot_px(0, 0, 3'b100);     // top-left red block
      plot_px(GW - 1, GH - 1, 3'b111); // bottom-right white block
      plot_px(3, 1, 3'b010);
      plot_px(3, 1, 3'b001);     // later write wins: blue
      plot_px(GW, 0, 3'b111);    // x out of range, would alias (0,1)
      plot_px(GW + 1, 0, 3'b111);// x out of range, would alias (1,1)
      plot_px(0, GH, 3'b111);    // y out of range
      plot_px(200, 1, 3'b111);   // x far out of range
      plot = 1'b0;

      exp_grid[0][0]           = 3'b100;
      exp_grid[GH - 1][GW - 1] = 3'b111;
      exp_grid[1][3]           = 3'b001;
      push_frame(2);

      // Reset in the middle of frame 3 (around line 4) with writes attempted.
      wait_fs(3, 2 * 2 * FT + 200);
      repeat (4 * 2 * HT) @(posedge clk);
      #1;
      resetn = 1'b0;
      x = 8'd0; y = 7'd0; colour = 3'b010; plot = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid reset");
      repeat (9) @(posedge clk);
      #1;
      x = 8'd2; y = 7'd1;
      @(negedge clk);
      check_reset_outputs("mid reset hold");
      push_frame(fs_count + 1);
      @(posedge clk); #1;
      plot = 1'b0; resetn = 1'b1;
      @(negedge clk);
      check("fs after mid reset, pre step", frame_start, 0);
      @(negedge clk);
      check("fs after mid reset, restart", frame_start, 1);

      wait_fs(5, 2 * FT + 200);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("scoreboard drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
